// File: rtl/trap_ctrl.sv
// Trap/interrupt arbiter feeding the CSR file: picks one trap per cycle
// by fixed priority, strobes the commit and holds a multi-cycle flush.
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_badaddr,
    input  logic [31:0]     ex_instr,
    input  logic            ex_fetch_mis,
    input  logic            ex_illegal,
    input  logic            ex_ebreak,
    input  logic            ex_ecall,
    input  logic            ex_ld_mis,
    input  logic            ex_st_mis,
    input  logic            ex_mret,
    input  logic [1:0]      current_mode,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            m_eie,
    input  logic            m_tie,
    output logic            exception_pending,
    output logic [XLEN-1:0] m_cause,
    output logic [XLEN-1:0] pc_exc,
    output logic [XLEN-1:0] m_tval,
    output logic            asy_int,
    output logic            m_ret,
    output logic            flush,
    output logic            trap_busy
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        FLUSH
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;

    logic            irq_ext;
    logic            irq_tmr;
    logic            any_exc;
    logic            trigger;
    logic [XLEN-1:0] cause_d;
    logic [XLEN-1:0] tval_d;
    logic            is_irq_d;
    logic            is_mret_d;

    assign irq_ext = sync_q[SYNC_STAGES-1] & m_eie;
    assign irq_tmr = timer_irq & m_tie;
    assign any_exc = ex_fetch_mis | ex_illegal | ex_ebreak
                   | ex_ecall | ex_ld_mis | ex_st_mis;
    assign trigger = (state_q == IDLE) & ex_valid & ~stall
                   & (irq_ext | irq_tmr | any_exc | ex_mret);
    assign trap_busy = (state_q != IDLE);

    always_comb begin
        cause_d   = '0;
        tval_d    = '0;
        is_irq_d  = 1'b0;
        is_mret_d = 1'b0;
        priority case (1'b1)
            irq_ext: begin
                cause_d  = {1'b1, (XLEN-1)'(11)};
                is_irq_d = 1'b1;
            end
            irq_tmr: begin
                cause_d  = {1'b1, (XLEN-1)'(7)};
                is_irq_d = 1'b1;
            end
            ex_fetch_mis: begin
                cause_d = XLEN'(0);
                tval_d  = ex_badaddr;
            end
            ex_illegal: begin
                cause_d = XLEN'(2);
                tval_d  = XLEN'(ex_instr);
            end
            ex_ebreak: cause_d = XLEN'(3);
            ex_ecall:
                cause_d = (current_mode == 2'd0) ? XLEN'(8) : XLEN'(11);
            ex_ld_mis: begin
                cause_d = XLEN'(4);
                tval_d  = ex_badaddr;
            end
            ex_st_mis: begin
                cause_d = XLEN'(6);
                tval_d  = ex_badaddr;
            end
            default: is_mret_d = ex_mret;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            sync_q            <= '0;
            exception_pending <= 1'b0;
            m_cause           <= '0;
            pc_exc            <= '0;
            m_tval            <= '0;
            asy_int           <= 1'b0;
            m_ret             <= 1'b0;
            flush             <= 1'b0;
        end else begin
            sync_q            <= {sync_q[SYNC_STAGES-2:0], ext_irq};
            exception_pending <= 1'b0;
            asy_int           <= 1'b0;
            m_ret             <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q           <= TRAP;
                        cnt_q             <= CW'(FLUSH_CYCLES - 1);
                        exception_pending <= 1'b1;
                        asy_int           <= is_irq_d;
                        m_ret             <= is_mret_d;
                        flush             <= 1'b1;
                        // mret leaves the last trap's CSR values untouched
                        if (!is_mret_d) begin
                            m_cause <= cause_d;
                            pc_exc  <= ex_pc;
                            m_tval  <= tval_d;
                        end
                    end
                end
                TRAP, FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        flush   <= 1'b0;
                    end else begin
                        state_q <= FLUSH;
                        cnt_q   <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected commits,
// a negedge monitor pops and compares every exception_pending strobe.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_badaddr;
    logic [31:0] ex_instr;
    logic        ex_fetch_mis, ex_illegal, ex_ebreak;
    logic        ex_ecall, ex_ld_mis, ex_st_mis;
    logic        ex_mret;
    logic [1:0]  current_mode;
    logic        ext_irq, timer_irq, m_eie, m_tie;
    logic        exception_pending;
    logic [31:0] m_cause, pc_exc, m_tval;
    logic        asy_int, m_ret, flush, trap_busy;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        asy;
        logic        mret;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_cause = '0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_tval = '0;

    trap_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_badaddr        (ex_badaddr),
        .ex_instr          (ex_instr),
        .ex_fetch_mis      (ex_fetch_mis),
        .ex_illegal        (ex_illegal),
        .ex_ebreak         (ex_ebreak),
        .ex_ecall          (ex_ecall),
        .ex_ld_mis         (ex_ld_mis),
        .ex_st_mis         (ex_st_mis),
        .ex_mret           (ex_mret),
        .current_mode      (current_mode),
        .ext_irq           (ext_irq),
        .timer_irq         (timer_irq),
        .m_eie             (m_eie),
        .m_tie             (m_tie),
        .exception_pending (exception_pending),
        .m_cause           (m_cause),
        .pc_exc            (pc_exc),
        .m_tval            (m_tval),
        .asy_int           (asy_int),
        .m_ret             (m_ret),
        .flush             (flush),
        .trap_busy         (trap_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exception_pending) begin
            exp_t e;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_commit: cause=%h pc=%h", m_cause, pc_exc);
            end else begin
                e = sb.pop_front();
                if (m_cause !== e.cause || pc_exc !== e.pc || m_tval !== e.tval
                    || asy_int !== e.asy || m_ret !== e.mret) begin
                    n_err++;
                    $display("FAIL commit: got cause=%h pc=%h tval=%h asy=%b mret=%b expected cause=%h pc=%h tval=%h asy=%b mret=%b",
                             m_cause, pc_exc, m_tval, asy_int, m_ret,
                             e.cause, e.pc, e.tval, e.asy, e.mret);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] p,
                        input logic [31:0] t, input logic a, input logic m);
        exp_t e;
        e.cause = c;
        e.pc    = p;
        e.tval  = t;
        e.asy   = a;
        e.mret  = m;
        sb.push_back(e);
        if (!m) begin
            last_cause = c;
            last_pc    = p;
            last_tval  = t;
        end
    endtask

    task automatic clear();
        ex_valid     = 1'b0;
        ex_fetch_mis = 1'b0;
        ex_illegal   = 1'b0;
        ex_ebreak    = 1'b0;
        ex_ecall     = 1'b0;
        ex_ld_mis    = 1'b0;
        ex_st_mis    = 1'b0;
        ex_mret      = 1'b0;
    endtask

    task automatic flush_chk(input string name);
        chk({name, "_flush1"}, {31'd0, flush}, 32'd1);
        chk({name, "_busy1"}, {31'd0, trap_busy}, 32'd1);
        tick();
        chk({name, "_flush2"}, {31'd0, flush}, 32'd1);
        tick();
        chk({name, "_flush_end"}, {31'd0, flush}, 32'd0);
        chk({name, "_busy_end"}, {31'd0, trap_busy}, 32'd0);
    endtask

    // f = {fetch_mis, illegal, ebreak, ecall, ld_mis, st_mis}
    task automatic fire(input string name, input logic [5:0] f,
                        input logic [1:0] mode, input logic [31:0] pc,
                        input logic [31:0] cause, input logic [31:0] tval);
        ex_valid     = 1'b1;
        ex_pc        = pc;
        current_mode = mode;
        {ex_fetch_mis, ex_illegal, ex_ebreak,
         ex_ecall, ex_ld_mis, ex_st_mis} = f;
        push(cause, pc, tval, 1'b0, 1'b0);
        tick();
        clear();
        flush_chk(name);
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        ex_pc        = '0;
        ex_badaddr   = 32'h0BAD_0001;
        ex_instr     = 32'hFFFF_FFFF;
        current_mode = 2'd3;
        ext_irq      = 1'b0;
        timer_irq    = 1'b0;
        m_eie        = 1'b0;
        m_tie        = 1'b0;
        clear();
        tick();
        tick();
        chk("rst_pending", {31'd0, exception_pending}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_busy", {31'd0, trap_busy}, 32'd0);
        chk("rst_cause", m_cause, 32'd0);
        chk("rst_pc", pc_exc, 32'd0);
        chk("rst_flags", {30'd0, asy_int, m_ret}, 32'd0);
        rst = 1'b0;
        tick();

        fire("illegal", 6'b010000, 2'd3, 32'h100, 32'd2, 32'hFFFF_FFFF);
        fire("prio_fetch", 6'b110010, 2'd3, 32'h104, 32'd0, 32'h0BAD_0001);
        fire("ebreak", 6'b001100, 2'd0, 32'h108, 32'd3, 32'd0);
        fire("ecall_u", 6'b000100, 2'd0, 32'h10C, 32'd8, 32'd0);
        fire("ecall_m", 6'b000100, 2'd3, 32'h110, 32'd11, 32'd0);
        fire("ld_st", 6'b000011, 2'd3, 32'h114, 32'd4, 32'h0BAD_0001);
        fire("st", 6'b000001, 2'd3, 32'h118, 32'd6, 32'h0BAD_0001);

        // timer beats a simultaneous U-mode ecall
        timer_irq    = 1'b1;
        m_tie        = 1'b1;
        current_mode = 2'd0;
        ex_valid     = 1'b1;
        ex_ecall     = 1'b1;
        ex_pc        = 32'h300;
        push(32'h8000_0007, 32'h300, 32'd0, 1'b1, 1'b0);
        tick();
        clear();
        flush_chk("timer");
        repeat (3) tick();

        // level irq held across TRAP/FLUSH is ignored there, retriggers in IDLE
        ex_valid = 1'b1;
        ex_pc    = 32'h400;
        push(32'h8000_0007, 32'h400, 32'd0, 1'b1, 1'b0);
        push(32'h8000_0007, 32'h400, 32'd0, 1'b1, 1'b0);
        repeat (4) tick();
        clear();
        timer_irq = 1'b0;
        m_tie     = 1'b0;
        tick();
        tick();
        chk("retrig_idle", {31'd0, trap_busy}, 32'd0);

        ex_valid = 1'b1;
        ex_mret  = 1'b1;
        ex_pc    = 32'h200;
        push(last_cause, last_pc, last_tval, 1'b0, 1'b1);
        tick();
        clear();
        chk("mret_asy", {31'd0, asy_int}, 32'd0);
        flush_chk("mret");
        chk("mret_cause_held", m_cause, 32'h8000_0007);

        ext_irq  = 1'b1;
        m_eie    = 1'b1;
        ex_valid = 1'b1;
        ex_pc    = 32'h500;
        push(32'h8000_000B, 32'h500, 32'd0, 1'b1, 1'b0);
        tick();
        chk("ext_edge1", {31'd0, exception_pending}, 32'd0);
        tick();
        chk("ext_edge2", {31'd0, exception_pending}, 32'd0);
        tick();
        chk("ext_edge3", {31'd0, exception_pending}, 32'd1);
        ext_irq = 1'b0;
        clear();
        repeat (4) tick();
        m_eie = 1'b0;

        ext_irq  = 1'b1;
        ex_valid = 1'b1;
        repeat (6) tick();
        chk("ext_masked_busy", {31'd0, trap_busy}, 32'd0);
        ext_irq = 1'b0;
        clear();
        repeat (3) tick();

        stall      = 1'b1;
        ex_valid   = 1'b1;
        ex_ld_mis  = 1'b1;
        ex_pc      = 32'h600;
        ex_badaddr = 32'hDEAD_0003;
        repeat (3) tick();
        chk("stall_busy", {31'd0, trap_busy}, 32'd0);
        push(32'd4, 32'h600, 32'hDEAD_0003, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        chk("stall_release", {31'd0, exception_pending}, 32'd1);
        clear();
        tick();
        tick();

        ex_valid  = 1'b1;
        ex_ebreak = 1'b1;
        ex_pc     = 32'h700;
        push(32'd3, 32'h700, 32'd0, 1'b0, 1'b0);
        tick();
        clear();
        tick();
        chk("rst_mid_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_flush_clr", {31'd0, flush}, 32'd0);
        chk("rst_busy_clr", {31'd0, trap_busy}, 32'd0);
        chk("rst_cause_clr", m_cause, 32'd0);
        tick();
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
